// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Read-side arbiter for the 2-master / 5-slave AXI bus. Grants one master per
// read transaction (fixed priority M0 over M1), decodes its ARADDR to a slave
// index, holds the route through the address and data phases and checks the
// R beat count against ARLEN.
//
// Ports
//   ACLK, ARESETn                  clock, asynchronous active-low reset
//   ARVALID/ARADDR/ARLEN_Mx        master read address request
//   ARREADY/RVALID/RLAST_Mx        muxed handshake signals, master side
//   RREADY_Mx                      master RREADY
//   Aibiter_Read_State_control     00 IDLE, 01 ADDR, 10 DATA
//   Arbiter_ARID_control           route {master, slave idx[2:0]}
//   rd_busy                        transaction in ADDR or DATA
//   rd_beat_err                    one-cycle pulse on RLAST / beat mismatch
// ---------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_E000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h0002_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h1000_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_FC00,
  parameter logic [31:0] S4_BASE = 32'h2000_0000,
  parameter logic [31:0] S4_MASK = 32'hFFE0_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  input  logic [31:0] ARADDR_M0,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M0,
  input  logic [3:0]  ARLEN_M1,
  input  logic        ARREADY_M0,
  input  logic        ARREADY_M1,
  input  logic        RVALID_M0,
  input  logic        RVALID_M1,
  input  logic        RREADY_M0,
  input  logic        RREADY_M1,
  input  logic        RLAST_M0,
  input  logic        RLAST_M1,
  output logic [1:0]  Aibiter_Read_State_control,
  output logic [3:0]  Arbiter_ARID_control,
  output logic        rd_busy,
  output logic        rd_beat_err
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned ROUTE_W = 4;
  localparam int unsigned SLV_W   = 3;

  localparam logic [ROUTE_W-1:0] NO_ROUTE  = 4'b0110;
  localparam logic [SLV_W-1:0]   DEF_SLAVE = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [ROUTE_W-1:0] route_q, route_d;
  logic               master_q, master_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               beat_err_q, beat_err_d;
  logic               busy_q, busy_d;

  // First matching window wins; a miss routes to the default slave.
  function automatic logic [SLV_W-1:0] decode(input logic [ADDR_W-1:0] addr);
    if      ((addr & S0_MASK) == S0_BASE) decode = 3'd0;
    else if ((addr & S1_MASK) == S1_BASE) decode = 3'd1;
    else if ((addr & S2_MASK) == S2_BASE) decode = 3'd2;
    else if ((addr & S3_MASK) == S3_BASE) decode = 3'd3;
    else if ((addr & S4_MASK) == S4_BASE) decode = 3'd4;
    else                                  decode = DEF_SLAVE;
  endfunction

  // Fixed-priority grant candidate, valid while in IDLE.
  logic [ROUTE_W-1:0] route_c;
  logic [LEN_W-1:0]   grant_len_c;
  logic               grant_ready_c;

  always_comb begin
    route_c       = NO_ROUTE;
    grant_len_c   = ARLEN_M0;
    grant_ready_c = ARREADY_M0;
    if (ARVALID_M0) begin
      route_c = {1'b0, decode(ARADDR_M0)};
    end else if (ARVALID_M1) begin
      route_c       = {1'b1, decode(ARADDR_M1)};
      grant_len_c   = ARLEN_M1;
      grant_ready_c = ARREADY_M1;
    end
  end

  // Handshake signals of the latched master only.
  logic sel_arvalid_c, sel_arready_c, sel_rvalid_c, sel_rready_c, sel_rlast_c;

  always_comb begin
    sel_arvalid_c = master_q ? ARVALID_M1 : ARVALID_M0;
    sel_arready_c = master_q ? ARREADY_M1 : ARREADY_M0;
    sel_rvalid_c  = master_q ? RVALID_M1  : RVALID_M0;
    sel_rready_c  = master_q ? RREADY_M1  : RREADY_M0;
    sel_rlast_c   = master_q ? RLAST_M1   : RLAST_M0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    master_d   = master_q;
    beat_cnt_d = beat_cnt_q;
    beat_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          route_d    = route_c;
          master_d   = ~ARVALID_M0;
          beat_cnt_d = grant_len_c;
          state_d    = grant_ready_c ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (sel_arvalid_c && sel_arready_c) state_d = DATA;
      end
      DATA: begin
        if (sel_rvalid_c && sel_rready_c) begin
          if (sel_rlast_c) begin
            state_d    = IDLE;
            beat_err_d = (beat_cnt_q != '0);
          end else if (beat_cnt_q == '0) begin
            // Extra beat past ARLEN: flag it, counter stays saturated.
            beat_err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      route_q    <= NO_ROUTE;
      master_q   <= 1'b0;
      beat_cnt_q <= '0;
      beat_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      master_q   <= master_d;
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
      busy_q     <= busy_d;
    end
  end

  // IDLE shows the live grant so the address mux can switch in the request
  // cycle; reset forces the no-route code regardless of request activity.
  assign Arbiter_ARID_control = !ARESETn          ? NO_ROUTE :
                                (state_q == IDLE) ? route_c  : route_q;
  assign Aibiter_Read_State_control = state_q;
  assign rd_busy     = busy_q;
  assign rd_beat_err = beat_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter
// Directed bench for axi_read_arbiter. Expected routes are queued when a
// request is driven and popped when the DUT enters the data phase.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ARVALID_M0, ARVALID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic        RVALID_M0, RVALID_M1;
  logic        RREADY_M0, RREADY_M1;
  logic        RLAST_M0, RLAST_M1;
  logic [1:0]  Aibiter_Read_State_control;
  logic [3:0]  Arbiter_ARID_control;
  logic        rd_busy;
  logic        rd_beat_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK                       (ACLK),
    .ARESETn                    (ARESETn),
    .ARVALID_M0                 (ARVALID_M0),
    .ARVALID_M1                 (ARVALID_M1),
    .ARADDR_M0                  (ARADDR_M0),
    .ARADDR_M1                  (ARADDR_M1),
    .ARLEN_M0                   (ARLEN_M0),
    .ARLEN_M1                   (ARLEN_M1),
    .ARREADY_M0                 (ARREADY_M0),
    .ARREADY_M1                 (ARREADY_M1),
    .RVALID_M0                  (RVALID_M0),
    .RVALID_M1                  (RVALID_M1),
    .RREADY_M0                  (RREADY_M0),
    .RREADY_M1                  (RREADY_M1),
    .RLAST_M0                   (RLAST_M0),
    .RLAST_M1                   (RLAST_M1),
    .Aibiter_Read_State_control (Aibiter_Read_State_control),
    .Arbiter_ARID_control       (Arbiter_ARID_control),
    .rd_busy                    (rd_busy),
    .rd_beat_err                (rd_beat_err)
  );

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Sample point, 4 time units after the rising edge.
  task automatic smp();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic bz, input logic er);
    chk({tag, ".state"}, 32'(Aibiter_Read_State_control), 32'(st));
    chk({tag, ".busy"},  32'(rd_busy),                    32'(bz));
    chk({tag, ".err"},   32'(rd_beat_err),                32'(er));
  endtask

  // Live grant must match the oldest outstanding expected route.
  task automatic sb_peek(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s observed=scoreboard-empty expected=route", tag);
    end else begin
      chk(tag, 32'(Arbiter_ARID_control), 32'(exp_q[0]));
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [3:0] r;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s observed=scoreboard-empty expected=route", tag);
    end else begin
      r = exp_q.pop_front();
      chk(tag, 32'(Arbiter_ARID_control), 32'(r));
    end
  endtask

  task automatic idle_all();
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    ARADDR_M0  = '0;   ARADDR_M1  = '0;
    ARLEN_M0   = '0;   ARLEN_M1   = '0;
    ARREADY_M0 = 1'b0; ARREADY_M1 = 1'b0;
    RVALID_M0  = 1'b0; RVALID_M1  = 1'b0;
    RREADY_M0  = 1'b0; RREADY_M1  = 1'b0;
    RLAST_M0   = 1'b0; RLAST_M1   = 1'b0;
  endtask

  task automatic beat_m0(input logic last);
    idle_all();
    RVALID_M0 = 1'b1; RREADY_M0 = 1'b1; RLAST_M0 = last;
  endtask

  initial begin
    ARESETn = 1'b0;
    idle_all();

    // Reset held with random input activity.
    #2;
    chk_st("rst0", 2'b00, 1'b0, 1'b0);
    chk("rst0.arid", 32'(Arbiter_ARID_control), 32'h6);
    for (int i = 0; i < 4; i++) begin
      cyc();
      ARVALID_M0 = 1'($urandom); ARVALID_M1 = 1'b1;
      ARADDR_M0  = $urandom;     ARADDR_M1  = $urandom;
      ARLEN_M0   = 4'($urandom); ARLEN_M1   = 4'($urandom);
      ARREADY_M0 = 1'($urandom); ARREADY_M1 = 1'($urandom);
      RVALID_M0  = 1'($urandom); RVALID_M1  = 1'($urandom);
      RREADY_M0  = 1'($urandom); RREADY_M1  = 1'($urandom);
      RLAST_M0   = 1'($urandom); RLAST_M1   = 1'($urandom);
      smp();
      chk_st("rst_hold", 2'b00, 1'b0, 1'b0);
      chk("rst_hold.arid", 32'(Arbiter_ARID_control), 32'h6);
    end
    cyc();
    idle_all();
    #4 ARESETn = 1'b1;

    // Single-beat M0 read to IM, ARREADY in the request cycle.
    cyc();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0040; ARLEN_M0 = 4'd0; ARREADY_M0 = 1'b1;
    exp_q.push_back(4'b0001);
    smp();
    chk_st("t2.req", 2'b00, 1'b0, 1'b0);
    sb_peek("t2.grant");
    cyc(); beat_m0(1'b1); smp();
    chk_st("t2.data", 2'b10, 1'b1, 1'b0);
    sb_pop("t2.route");
    cyc(); idle_all(); smp();
    chk_st("t2.done", 2'b00, 1'b0, 1'b0);
    chk("t2.idle_arid", 32'(Arbiter_ARID_control), 32'h6);

    // Simultaneous requests: M0 first, M1 granted right after M0's RLAST.
    cyc();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0100; ARLEN_M0 = 4'd1; ARREADY_M0 = 1'b1;
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h2000_0000; ARLEN_M1 = 4'd0;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1100);
    smp();
    sb_peek("t3.grant_m0");
    cyc();
    ARVALID_M0 = 1'b0; ARREADY_M0 = 1'b0;
    RVALID_M0 = 1'b1; RREADY_M0 = 1'b1; RLAST_M0 = 1'b0;
    smp();
    chk_st("t3.m0_b1", 2'b10, 1'b1, 1'b0);
    sb_pop("t3.route_m0");
    cyc(); RLAST_M0 = 1'b1; smp();
    chk_st("t3.m0_b2", 2'b10, 1'b1, 1'b0);
    chk("t3.m0_hold", 32'(Arbiter_ARID_control), 32'h0);
    cyc();
    RVALID_M0 = 1'b0; RREADY_M0 = 1'b0; RLAST_M0 = 1'b0; ARREADY_M1 = 1'b1;
    smp();
    chk_st("t3.rearb", 2'b00, 1'b0, 1'b0);
    sb_peek("t3.grant_m1");
    cyc();
    idle_all(); RVALID_M1 = 1'b1; RREADY_M1 = 1'b1; RLAST_M1 = 1'b1;
    smp();
    chk_st("t3.m1_data", 2'b10, 1'b1, 1'b0);
    sb_pop("t3.route_m1");
    cyc(); idle_all(); smp();
    chk_st("t3.done", 2'b00, 1'b0, 1'b0);

    // M1 to an unmapped address, ARREADY late; M0 request ignored in ADDR.
    cyc();
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h3000_0000; ARLEN_M1 = 4'd0;
    exp_q.push_back(4'b1111);
    smp();
    sb_peek("t4.grant");
    for (int i = 0; i < 3; i++) begin
      cyc();
      ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000;
      ARREADY_M1 = (i == 2);
      smp();
      chk_st("t4.addr", 2'b01, 1'b1, 1'b0);
      chk("t4.addr_arid", 32'(Arbiter_ARID_control), 32'hF);
    end
    cyc();
    idle_all(); RVALID_M1 = 1'b1; RREADY_M1 = 1'b1; RLAST_M1 = 1'b1;
    smp();
    chk_st("t4.data", 2'b10, 1'b1, 1'b0);
    sb_pop("t4.route");
    cyc(); idle_all(); smp();
    chk_st("t4.done", 2'b00, 1'b0, 1'b0);

    // ARLEN 3 with early RLAST on beat 2.
    cyc();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h1000_0000; ARLEN_M0 = 4'd3; ARREADY_M0 = 1'b1;
    exp_q.push_back(4'b0011);
    smp();
    sb_peek("t5a.grant");
    cyc(); beat_m0(1'b0); smp();
    chk_st("t5a.b1", 2'b10, 1'b1, 1'b0);
    sb_pop("t5a.route");
    cyc(); beat_m0(1'b1); smp();
    chk_st("t5a.b2", 2'b10, 1'b1, 1'b0);
    cyc(); idle_all(); smp();
    chk_st("t5a.pulse", 2'b00, 1'b0, 1'b1);
    cyc(); smp();
    chk_st("t5a.after", 2'b00, 1'b0, 1'b0);

    // ARLEN 1 with beats past the end before RLAST; gaps separate pulses.
    cyc();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0002_0010; ARLEN_M0 = 4'd1; ARREADY_M0 = 1'b1;
    exp_q.push_back(4'b0010);
    smp();
    sb_peek("t5b.grant");
    cyc(); beat_m0(1'b0); smp();
    chk_st("t5b.b1", 2'b10, 1'b1, 1'b0);
    sb_pop("t5b.route");
    cyc(); idle_all(); smp();
    chk_st("t5b.gap1", 2'b10, 1'b1, 1'b0);
    cyc(); beat_m0(1'b0); smp();
    chk_st("t5b.b2", 2'b10, 1'b1, 1'b0);
    cyc(); idle_all(); smp();
    chk_st("t5b.gap2", 2'b10, 1'b1, 1'b1);
    cyc(); beat_m0(1'b0); smp();
    chk_st("t5b.b3", 2'b10, 1'b1, 1'b0);
    cyc(); idle_all(); smp();
    chk_st("t5b.gap3", 2'b10, 1'b1, 1'b1);
    cyc(); beat_m0(1'b1); smp();
    chk_st("t5b.b4", 2'b10, 1'b1, 1'b0);
    cyc(); idle_all(); smp();
    chk_st("t5b.done", 2'b00, 1'b0, 1'b0);

    // Reset asserted during beat 2 of 4, then a normal M1 transaction.
    cyc();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h2000_1234; ARLEN_M0 = 4'd3; ARREADY_M0 = 1'b1;
    exp_q.push_back(4'b0100);
    smp();
    sb_peek("t6.grant");
    cyc(); beat_m0(1'b0); smp();
    chk_st("t6.b1", 2'b10, 1'b1, 1'b0);
    sb_pop("t6.route");
    cyc(); beat_m0(1'b0);
    #1 ARESETn = 1'b0;
    #2;
    chk_st("t6.abort", 2'b00, 1'b0, 1'b0);
    chk("t6.abort_arid", 32'(Arbiter_ARID_control), 32'h6);
    cyc(); idle_all();
    #4 ARESETn = 1'b1;
    cyc(); smp();
    chk_st("t6.released", 2'b00, 1'b0, 1'b0);
    cyc();
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0000; ARLEN_M1 = 4'd0; ARREADY_M1 = 1'b1;
    exp_q.push_back(4'b1010);
    smp();
    sb_peek("t6.grant_m1");
    cyc();
    idle_all(); RVALID_M1 = 1'b1; RREADY_M1 = 1'b1; RLAST_M1 = 1'b1;
    smp();
    chk_st("t6.m1_data", 2'b10, 1'b1, 1'b0);
    sb_pop("t6.route_m1");
    cyc(); idle_all(); smp();
    chk_st("t6.done", 2'b00, 1'b0, 1'b0);
    chk("t6.sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
